ram_fill_ctrl: RTL and testbench

Upstream sequencer that drives the in/addr/load side of a RAM512. On a start pulse it writes a block of consecutive words, constant or incrementing pattern, from a base address, one word per clock. Used for memory clear at boot, test-pattern fill and bench stimulus in place of free-running counters. Start/busy/done handshake to the controlling logic.

---
 rtl/ram_fill_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ram_fill_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fill_ctrl.sv
// Block fill sequencer for a RAM512: writes constant or incrementing words.
// Optional read-back check of the filled range under RAM_FILL_VERIFY_EN.
module ram_fill_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] seed,
  input  logic              incr,
  input  logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_load,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

`ifdef RAM_FILL_VERIFY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_DONE   = 2'd2,
    S_VERIFY = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              incr_q, incr_d;
  logic [ADDR_W:0]   clamp;

`ifdef RAM_FILL_VERIFY_EN
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
`else
  logic unused_ram_out;
  assign unused_ram_out = ^ram_out;
`endif

  assign clamp = (count > MAX_CNT) ? MAX_CNT : count;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rem_d   = rem_q;
    load_d  = load_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    incr_d  = incr_q;
`ifdef RAM_FILL_VERIFY_EN
    base_d  = base_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          incr_d = incr;
`ifdef RAM_FILL_VERIFY_EN
          base_d = base_addr;
          seed_d = seed;
          cnt_d  = clamp;
          err_d  = 1'b0;
`endif
          if (clamp != '0) begin
            state_d = S_FILL;
            load_d  = 1'b1;
            busy_d  = 1'b1;
            addr_d  = base_addr;
            data_d  = seed;
            rem_d   = clamp;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (rem_q == ONE) begin
          load_d = 1'b0;
`ifdef RAM_FILL_VERIFY_EN
          // re-walk the range; data_q now carries the expected word
          state_d = S_VERIFY;
          addr_d  = base_q;
          data_d  = seed_q;
          rem_d   = cnt_q;
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          data_d = data_q + DATA_W'(incr_q);
          rem_d  = rem_q - ONE;
        end
      end
`ifdef RAM_FILL_VERIFY_EN
      S_VERIFY: begin
        if (ram_out != data_q) begin
          err_d = 1'b1;
        end
        if (rem_q == ONE) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          data_d = data_q + DATA_W'(incr_q);
          rem_d  = rem_q - ONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      incr_q  <= 1'b0;
`ifdef RAM_FILL_VERIFY_EN
      base_q  <= '0;
      seed_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      incr_q  <= incr_d;
`ifdef RAM_FILL_VERIFY_EN
      base_q  <= base_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ram_in   = data_q;
  assign ram_addr = addr_q;
  assign ram_load = load_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef RAM_FILL_VERIFY_EN
  assign error    = err_q;
`else
  assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fill_ctrl.sv
// Bench for ram_fill_ctrl: RAM512 model, write scoreboard, directed steps.
module tb_ram_fill_ctrl;

  localparam int AW = 9;
  localparam int DW = 16;
`ifdef RAM_FILL_VERIFY_EN
  localparam int VMUL = 2;
`else
  localparam int VMUL = 1;
`endif

  logic          clk = 1'b0;
  logic          reset, start, incr;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic [DW-1:0] seed;
  logic [DW-1:0] ram_out, ram_in;
  logic [AW-1:0] ram_addr;
  logic          ram_load, busy, done, error;

  logic [DW-1:0] mem [512];
  logic          clr = 1'b0;
  logic          corrupt = 1'b0;

  int vec = 0;
  int miss = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t q[$];
  wr_t e_m;

  always #5 clk = ~clk;

  ram_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .count(count),
    .seed(seed), .incr(incr), .ram_out(ram_out),
    .ram_in(ram_in), .ram_addr(ram_addr),
    .ram_load(ram_load), .busy(busy),
    .done(done), .error(error)
  );

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 16'hDEAD;
    end else if (ram_load) begin
      mem[ram_addr] <= ram_in;
    end
  end

  assign ram_out = corrupt ? '0 : mem[ram_addr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("done_vs_load", 32'(ram_load), 0);
    end
    if (ram_load) begin
      wr_cnt++;
      if (q.size() == 0) begin
        chk("spurious_write", 32'(ram_load), 0);
      end else begin
        e_m = q.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(e_m.a));
        chk("wr_data", 32'(ram_in), 32'(e_m.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fill(input logic [AW-1:0] b, input int n,
                           input logic [DW-1:0] sd, input logic inc);
    int m;
    wr_t w;
    m = (n > 512) ? 512 : n;
    for (int i = 0; i < m; i++) begin
      w.a = b + AW'(i);
      w.d = inc ? sd + DW'(i) : sd;
      q.push_back(w);
    end
  endtask

  task automatic go(input logic [AW-1:0] b, input int n,
                    input logic [DW-1:0] sd, input logic inc);
    push_fill(b, n, sd, inc);
    base_addr = b;
    count     = (AW+1)'(n);
    seed      = sd;
    incr      = inc;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < lim) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int c, w0, dc0, bad;
    logic [DW-1:0] old2;
    reset = 1'b1; start = 1'b0; incr = 1'b0;
    base_addr = '0; count = '0; seed = '0;
    clr = 1'b1;
    tick(); tick(); tick();
    clr = 1'b0;
    chk("rst_ram_in", 32'(ram_in), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_load", 32'(ram_load), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    reset = 1'b0;
    tick();

    // basic incrementing fill
    go(9'h199, 4, 16'hABCD, 1'b1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_load", 32'(ram_load), 1);
    chk("t1_addr0", 32'(ram_addr), 32'h199);
    chk("t1_data0", 32'(ram_in), 32'hABCD);
    wait_done(100, c);
    chk("t1_cycles", c, 4 * VMUL);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_error", 32'(error), 0);
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_q_empty", q.size(), 0);
    chk("t1_writes", wr_cnt, 4);
    for (int i = 0; i < 4; i++)
      chk("t1_readback", 32'(mem[9'h199 + i]), 32'(16'hABCD + i));

    // address and data wrap
    w0 = wr_cnt;
    go(9'h1FE, 4, 16'hFFFF, 1'b1);
    wait_done(100, c);
    chk("t2_cycles", c, 4 * VMUL);
    tick();
    chk("t2_writes", wr_cnt - w0, 4);
    chk("t2_mem1fe", 32'(mem[9'h1FE]), 32'hFFFF);
    chk("t2_mem1ff", 32'(mem[9'h1FF]), 32'h0000);
    chk("t2_mem000", 32'(mem[0]), 32'h0001);
    chk("t2_mem001", 32'(mem[1]), 32'h0002);

    // zero count, then clamped full clear
    w0 = wr_cnt;
    go(9'h0AA, 0, 16'h5555, 1'b1);
    chk("t3_zero_done", 32'(done), 1);
    chk("t3_zero_busy", 32'(busy), 0);
    chk("t3_zero_load", 32'(ram_load), 0);
    tick();
    chk("t3_zero_done_end", 32'(done), 0);
    chk("t3_zero_writes", wr_cnt - w0, 0);
    go(9'h0AA, 600, 16'h0000, 1'b0);
    wait_done(3000, c);
    chk("t3_clamp_cycles", c, 512 * VMUL);
    tick();
    chk("t3_clamp_writes", wr_cnt - w0, 512);
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== 16'h0000) bad++;
    chk("t3_all_zero", bad, 0);

    // start during fill is ignored
    w0 = wr_cnt;
    go(9'h020, 8, 16'h0100, 1'b1);
    tick(); tick();
    base_addr = 9'h0F0; count = 10'd3; seed = 16'h0007;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, c);
    chk("t4_cycles", c, 8 * VMUL - 3);
    tick(); tick();
    chk("t4_writes", wr_cnt - w0, 8);
    chk("t4_no_requeue", 32'(busy), 0);
    chk("t4_q_empty", q.size(), 0);

    // start held high re-triggers after one idle cycle
    w0 = wr_cnt;
    push_fill(9'h040, 3, 16'h0A00, 1'b1);
    push_fill(9'h040, 3, 16'h0A00, 1'b1);
    base_addr = 9'h040; count = 10'd3; seed = 16'h0A00; incr = 1'b1;
    start = 1'b1;
    tick();
    wait_done(100, c);
    chk("t4h_cycles1", c, 3 * VMUL);
    tick();
    chk("t4h_idle_load", 32'(ram_load), 0);
    chk("t4h_idle_busy", 32'(busy), 0);
    tick();
    chk("t4h_retrig_load", 32'(ram_load), 1);
    chk("t4h_retrig_addr", 32'(ram_addr), 32'h040);
    start = 1'b0;
    wait_done(100, c);
    chk("t4h_cycles2", c, 3 * VMUL);
    tick(); tick();
    chk("t4h_writes", wr_cnt - w0, 6);
    chk("t4h_busy_end", 32'(busy), 0);

    // reset after two writes
    w0 = wr_cnt;
    old2 = mem[9'h102];
    dc0 = done_cnt;
    push_fill(9'h100, 2, 16'h7777, 1'b1);
    base_addr = 9'h100; count = 10'd8; seed = 16'h7777; incr = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("t5_load", 32'(ram_load), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("t5_no_done", done_cnt - dc0, 0);
    chk("t5_writes", wr_cnt - w0, 2);
    chk("t5_mem100", 32'(mem[9'h100]), 32'h7777);
    chk("t5_mem101", 32'(mem[9'h101]), 32'h7778);
    chk("t5_mem102", 32'(mem[9'h102]), 32'(old2));

`ifdef RAM_FILL_VERIFY_EN
    go(9'h180, 8, 16'h0055, 1'b1);
    wait_done(100, c);
    chk("t6_clean_cycles", c, 16);
    chk("t6_clean_error", 32'(error), 0);
    tick();
    go(9'h180, 8, 16'h1234, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    chk("t6_verify_busy", 32'(busy), 1);
    chk("t6_verify_load", 32'(ram_load), 0);
    corrupt = 1'b1;
    tick();
    corrupt = 1'b0;
    wait_done(100, c);
    chk("t6_error_set", 32'(error), 1);
    tick();
    chk("t6_error_sticky", 32'(error), 1);
    go(9'h180, 0, 16'h0000, 1'b0);
    chk("t6_error_clear", 32'(error), 0);
    tick();
`endif

    chk("end_q_empty", q.size(), 0);
    chk("end_error", 32'(error), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
